// File: rtl/dcache_ctrl.sv
// Dcache sequencer between the LSQ and the tagged memory bus: probes for load hits,
// tracks load misses in a tag-keyed MSHR table, writes fills and write-through stores.
module dcache_ctrl #(
  parameter int MSHR_DEPTH = 4,
  parameter int ID_W       = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            lsq_req_valid,
  input  logic            lsq_req_is_store,
  input  logic [63:0]     lsq_req_addr,
  input  logic [63:0]     lsq_req_data,
  input  logic [ID_W-1:0] lsq_req_id,
  output logic            lsq_req_ready,
  output logic            lsq_resp_valid,
  output logic [ID_W-1:0] lsq_resp_id,
  output logic [63:0]     lsq_resp_data,
  output logic [5:0]      dc_rd_idx,
  output logic [54:0]     dc_rd_tag,
  input  logic [63:0]     dc_rd_data,
  input  logic            dc_rd_valid,
  output logic            dc_wrA_en,
  output logic [5:0]      dc_wrA_idx,
  output logic [54:0]     dc_wrA_tag,
  output logic [63:0]     dc_wrA_data,
  output logic            dc_wrB_en,
  output logic [5:0]      dc_wrB_idx,
  output logic [54:0]     dc_wrB_tag,
  output logic [63:0]     dc_wrB_data,
  output logic [1:0]      proc2mem_command,
  output logic [63:0]     proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag
);
  localparam int IDX_W = (MSHR_DEPTH > 1) ? $clog2(MSHR_DEPTH) : 1;
  localparam int CNT_W = $clog2(MSHR_DEPTH + 1);

  typedef enum logic {IDLE, RETRY} state_t;
  state_t state, state_n;

  logic [MSHR_DEPTH-1:0]           m_vld, m_stale;
  logic [MSHR_DEPTH-1:0][60:0]     m_line;
  logic [MSHR_DEPTH-1:0][ID_W-1:0] m_id;
  logic [MSHR_DEPTH-1:0][3:0]      m_tag;

  logic            rt_store;
  logic [60:0]     rt_line;
  logic [63:0]     rt_data;
  logic [ID_W-1:0] rt_id;

  logic             fill_hit;
  logic [IDX_W-1:0] fill_sel, free_sel;
  logic [CNT_W-1:0] m_cnt;
  logic             accept, issue, done, cmd_store;
  logic [60:0]      req_line, cmd_line;
  logic [63:0]      cmd_data;
  logic [ID_W-1:0]  cmd_id;
  logic             unused_ok;

  assign unused_ok = ^lsq_req_addr[2:0];
  assign req_line  = lsq_req_addr[63:3];

  always_comb begin
    fill_hit = 1'b0;
    fill_sel = '0;
    free_sel = '0;
    m_cnt    = '0;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      m_cnt = m_cnt + CNT_W'(m_vld[i]);
      if (m_vld[i] && mem2proc_tag != 4'd0 && m_tag[i] == mem2proc_tag) begin
        fill_hit = 1'b1;
        fill_sel = IDX_W'(i);
      end
    end
    // entry being filled this cycle stays busy until next cycle
    for (int i = MSHR_DEPTH - 1; i >= 0; i--)
      if (!m_vld[i]) free_sel = IDX_W'(i);
  end

  assign lsq_req_ready = !reset && state == IDLE && m_cnt < CNT_W'(MSHR_DEPTH) && !fill_hit;
  assign accept        = lsq_req_valid && lsq_req_ready;

  assign dc_rd_idx = lsq_req_addr[8:3];
  assign dc_rd_tag = lsq_req_addr[63:9];

  assign dc_wrA_en   = accept && lsq_req_is_store;
  assign dc_wrA_idx  = lsq_req_addr[8:3];
  assign dc_wrA_tag  = lsq_req_addr[63:9];
  assign dc_wrA_data = lsq_req_data;

  assign dc_wrB_en   = !reset && fill_hit && !m_stale[fill_sel];
  assign dc_wrB_idx  = m_line[fill_sel][5:0];
  assign dc_wrB_tag  = m_line[fill_sel][60:6];
  assign dc_wrB_data = mem2proc_data;

  always_comb begin
    state_n   = state;
    issue     = 1'b0;
    cmd_store = lsq_req_is_store;
    cmd_line  = req_line;
    cmd_data  = lsq_req_data;
    cmd_id    = lsq_req_id;
    if (!reset) begin
      case (state)
        IDLE: begin
          issue = accept && (lsq_req_is_store || !dc_rd_valid);
          if (issue && mem2proc_response == 4'd0) state_n = RETRY;
        end
        RETRY: begin
          cmd_store = rt_store;
          cmd_line  = rt_line;
          cmd_data  = rt_data;
          cmd_id    = rt_id;
          // a store completion would collide with the fill response, so hold it a cycle
          issue = !(rt_store && fill_hit);
          if (issue && mem2proc_response != 4'd0) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign done             = issue && mem2proc_response != 4'd0;
  assign proc2mem_command = !issue ? 2'd0 : (cmd_store ? 2'd2 : 2'd1);
  assign proc2mem_addr    = {cmd_line, 3'b000};
  assign proc2mem_data    = cmd_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      m_vld          <= '0;
      m_stale        <= '0;
      lsq_resp_valid <= 1'b0;
    end else begin
      state          <= state_n;
      lsq_resp_valid <= 1'b0;
      if (fill_hit) begin
        m_vld[fill_sel] <= 1'b0;
        lsq_resp_valid  <= 1'b1;
        lsq_resp_id     <= m_id[fill_sel];
        lsq_resp_data   <= mem2proc_data;
      end
      if (accept && lsq_req_is_store) begin
        for (int i = 0; i < MSHR_DEPTH; i++)
          if (m_vld[i] && m_line[i] == req_line) m_stale[i] <= 1'b1;
      end
      if (accept && !lsq_req_is_store && dc_rd_valid) begin
        lsq_resp_valid <= 1'b1;
        lsq_resp_id    <= lsq_req_id;
        lsq_resp_data  <= dc_rd_data;
      end
      if (done && cmd_store) begin
        lsq_resp_valid <= 1'b1;
        lsq_resp_id    <= cmd_id;
        lsq_resp_data  <= cmd_data;
      end
      if (done && !cmd_store) begin
        m_vld[free_sel]   <= 1'b1;
        m_stale[free_sel] <= 1'b0;
        m_line[free_sel]  <= cmd_line;
        m_id[free_sel]    <= cmd_id;
        m_tag[free_sel]   <= mem2proc_response;
      end
      if (state == IDLE && issue && !done) begin
        rt_store <= cmd_store;
        rt_line  <= cmd_line;
        rt_data  <= cmd_data;
        rt_id    <= cmd_id;
      end
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: acts as cache array and memory bus, predicts every cycle's
// outputs from a transaction-level model (MSHRs keyed by tag, line-addressed cache).
module tb_dcache_ctrl;
  localparam int ID_W  = 5;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset;
  logic lsq_req_valid, lsq_req_is_store, lsq_req_ready, lsq_resp_valid;
  logic [63:0] lsq_req_addr, lsq_req_data, lsq_resp_data;
  logic [ID_W-1:0] lsq_req_id, lsq_resp_id;
  logic [5:0] dc_rd_idx, dc_wrA_idx, dc_wrB_idx;
  logic [54:0] dc_rd_tag, dc_wrA_tag, dc_wrB_tag;
  logic [63:0] dc_rd_data, dc_wrA_data, dc_wrB_data;
  logic dc_rd_valid, dc_wrA_en, dc_wrB_en;
  logic [1:0] proc2mem_command;
  logic [63:0] proc2mem_addr, proc2mem_data, mem2proc_data;
  logic [3:0] mem2proc_response, mem2proc_tag;

  always #5 clock = ~clock;

  dcache_ctrl #(.MSHR_DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset),
    .lsq_req_valid(lsq_req_valid), .lsq_req_is_store(lsq_req_is_store),
    .lsq_req_addr(lsq_req_addr), .lsq_req_data(lsq_req_data), .lsq_req_id(lsq_req_id),
    .lsq_req_ready(lsq_req_ready), .lsq_resp_valid(lsq_resp_valid),
    .lsq_resp_id(lsq_resp_id), .lsq_resp_data(lsq_resp_data),
    .dc_rd_idx(dc_rd_idx), .dc_rd_tag(dc_rd_tag), .dc_rd_data(dc_rd_data), .dc_rd_valid(dc_rd_valid),
    .dc_wrA_en(dc_wrA_en), .dc_wrA_idx(dc_wrA_idx), .dc_wrA_tag(dc_wrA_tag), .dc_wrA_data(dc_wrA_data),
    .dc_wrB_en(dc_wrB_en), .dc_wrB_idx(dc_wrB_idx), .dc_wrB_tag(dc_wrB_tag), .dc_wrB_data(dc_wrB_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [60:0]     line;
    logic [ID_W-1:0] id;
    bit              stale;
  } mshr_t;

  mshr_t       mm     [int];           // outstanding misses by memory tag
  logic [63:0] mcache [logic [60:0]];  // model's view of cache contents
  logic [63:0] ecache [logic [60:0]];  // cache array as written by the DUT
  bit              rt_pend, rt_st;
  logic [60:0]     rt_line;
  logic [63:0]     rt_data;
  logic [ID_W-1:0] rt_id;
  bit              x_rv;
  logic [ID_W-1:0] x_rid;
  logic [63:0]     x_rdata;

  bit              s_rst, s_valid, s_store;
  logic [63:0]     s_addr, s_data, s_mdata;
  logic [ID_W-1:0] s_id;
  logic [3:0]      s_tag;
  int              force_resp;
  logic [1:0]      o_cmd;
  logic            o_ready, o_wrb_en;
  logic [5:0]      o_wrb_idx;

  task automatic step();
    logic [60:0] line, rl, cline;
    logic [63:0] cdata;
    logic [ID_W-1:0] cid;
    logic [1:0] e_cmd;
    logic [3:0] rsp;
    bit fh, e_ready, acc, m_hit, e_wrb, st_cmd;
    mshr_t fe;
    reset = s_rst;
    lsq_req_valid = s_valid;
    lsq_req_is_store = s_store;
    lsq_req_addr = s_addr;
    lsq_req_data = s_data;
    lsq_req_id = s_id;
    mem2proc_tag = s_tag;
    mem2proc_data = s_mdata;
    mem2proc_response = 4'd0;
    #1;
    rl = {dc_rd_tag, dc_rd_idx};
    dc_rd_valid = ecache.exists(rl);
    dc_rd_data = dc_rd_valid ? ecache[rl] : 64'h0;

    line = s_addr[63:3];
    fh = s_tag != 4'd0 && mm.exists(int'(s_tag));
    fe = '{line: '0, id: '0, stale: 1'b0};
    if (fh) fe = mm[int'(s_tag)];
    e_ready = !s_rst && !rt_pend && mm.num() < DEPTH && !fh;
    acc = s_valid && e_ready;
    m_hit = mcache.exists(line);
    e_cmd = 2'd0;
    cline = line; cdata = s_data; cid = s_id; st_cmd = s_store;
    if (!s_rst) begin
      if (rt_pend) begin
        cline = rt_line; cdata = rt_data; cid = rt_id; st_cmd = rt_st;
        if (!(rt_st && fh)) e_cmd = rt_st ? 2'd2 : 2'd1;
      end else if (acc) begin
        e_cmd = s_store ? 2'd2 : (m_hit ? 2'd0 : 2'd1);
      end
    end
    rsp = 4'd0;
    if (e_cmd != 2'd0) begin
      if (force_resp >= 0) rsp = 4'(force_resp);
      else if ($urandom_range(0, 2) != 0) begin
        do rsp = 4'($urandom_range(1, 15)); while (mm.exists(int'(rsp)) || rsp == s_tag);
      end
    end
    mem2proc_response = rsp;
    #1;
    o_ready = lsq_req_ready; o_cmd = proc2mem_command;
    o_wrb_en = dc_wrB_en; o_wrb_idx = dc_wrB_idx;
    chk("ready", 64'(lsq_req_ready), 64'(e_ready));
    chk("mem_cmd", 64'(proc2mem_command), 64'(e_cmd));
    if (e_cmd != 2'd0) chk("mem_addr", proc2mem_addr, {cline, 3'b000});
    if (e_cmd == 2'd2) chk("mem_data", proc2mem_data, cdata);
    chk("wrA_en", 64'(dc_wrA_en), 64'(acc && s_store));
    if (acc && s_store) begin
      chk("wrA_line", 64'({dc_wrA_tag, dc_wrA_idx}), 64'(line));
      chk("wrA_data", dc_wrA_data, s_data);
    end
    e_wrb = !s_rst && fh && !fe.stale;
    chk("wrB_en", 64'(dc_wrB_en), 64'(e_wrb));
    if (e_wrb) begin
      chk("wrB_line", 64'({dc_wrB_tag, dc_wrB_idx}), 64'(fe.line));
      chk("wrB_data", dc_wrB_data, s_mdata);
    end
    if (acc && !s_store) chk("rd_line", 64'({dc_rd_tag, dc_rd_idx}), 64'(line));
    if (dc_wrA_en === 1'b1) ecache[{dc_wrA_tag, dc_wrA_idx}] = dc_wrA_data;
    if (dc_wrB_en === 1'b1) ecache[{dc_wrB_tag, dc_wrB_idx}] = dc_wrB_data;

    x_rv = 1'b0;
    if (s_rst) begin
      mm.delete();
      rt_pend = 1'b0;
    end else begin
      if (fh) begin
        x_rv = 1'b1; x_rid = fe.id; x_rdata = s_mdata;
        if (!fe.stale) mcache[fe.line] = s_mdata;
        mm.delete(int'(s_tag));
      end
      if (acc && s_store) begin
        foreach (mm[k]) if (mm[k].line == line) mm[k].stale = 1'b1;
        mcache[line] = s_data;
      end
      if (acc && !s_store && m_hit) begin
        x_rv = 1'b1; x_rid = s_id; x_rdata = mcache[line];
      end
      if (e_cmd != 2'd0) begin
        if (rsp != 4'd0) begin
          if (st_cmd) begin x_rv = 1'b1; x_rid = cid; x_rdata = cdata; end
          else mm[int'(rsp)] = '{line: cline, id: cid, stale: 1'b0};
          rt_pend = 1'b0;
        end else if (!rt_pend) begin
          rt_pend = 1'b1; rt_st = st_cmd; rt_line = cline; rt_data = cdata; rt_id = cid;
        end
      end
    end
    @(posedge clock);
    #1;
    chk("resp_valid", 64'(lsq_resp_valid), 64'(x_rv));
    if (x_rv) begin
      chk("resp_id", 64'(lsq_resp_id), 64'(x_rid));
      chk("resp_data", lsq_resp_data, x_rdata);
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0; s_tag = 4'd0; force_resp = -1;
    repeat (n) step();
  endtask

  task automatic req(input bit st, input logic [63:0] a, input logic [63:0] d,
                     input logic [ID_W-1:0] id, input int r);
    s_valid = 1'b1; s_store = st; s_addr = a; s_data = d; s_id = id;
    s_tag = 4'd0; force_resp = r;
    step();
    s_valid = 1'b0; force_resp = -1;
  endtask

  task automatic fill(input logic [3:0] t, input logic [63:0] d);
    s_valid = 1'b0; s_tag = t; s_mdata = d;
    step();
    s_tag = 4'd0;
  endtask

  initial begin
    int nl;
    int keys[$];
    s_rst = 1'b1; s_valid = 1'b0; s_store = 1'b0; s_addr = '0; s_data = '0;
    s_id = '0; s_tag = '0; s_mdata = '0; force_resp = -1;
    rt_pend = 1'b0; x_rv = 1'b0;
    dc_rd_valid = 1'b0; dc_rd_data = '0;
    #2;
    step(); step();
    chk("rst_ready", 64'(o_ready), 64'd0);
    chk("rst_cmd", 64'(o_cmd), 64'd0);
    chk("rst_resp", 64'(lsq_resp_valid), 64'd0);
    s_rst = 1'b0;
    idle(1);
    chk("idle_ready", 64'(o_ready), 64'd1);

    // load hit
    mcache[61'(64'h1008 >> 3)] = 64'hDEAD_BEEF_0000_1008;
    ecache[61'(64'h1008 >> 3)] = 64'hDEAD_BEEF_0000_1008;
    req(1'b0, 64'h1008, 64'h0, 5'd3, 0);
    chk("hit_cmd", 64'(o_cmd), 64'd0);
    chk("hit_id", 64'(lsq_resp_id), 64'd3);
    chk("hit_data", lsq_resp_data, 64'hDEAD_BEEF_0000_1008);

    // load miss then fill
    req(1'b0, 64'h8, 64'h0, 5'd7, 5);
    chk("miss_cmd", 64'(o_cmd), 64'd1);
    idle(2);
    fill(4'd5, 64'hAB);
    chk("fill_wrB_en", 64'(o_wrb_en), 64'd1);
    chk("fill_wrB_idx", 64'(o_wrb_idx), 64'd1);
    chk("fill_id", 64'(lsq_resp_id), 64'd7);
    chk("fill_data", lsq_resp_data, 64'hAB);
    fill(4'd5, 64'hCD);
    chk("freed_resp", 64'(lsq_resp_valid), 64'd0);

    // memory busy: three refusals then tag 6
    s_valid = 1'b1; s_store = 1'b0; s_addr = 64'h40; s_id = 5'd9; force_resp = 0;
    step();
    nl = (o_cmd == 2'd1) ? 1 : 0;
    s_id = 5'd10;
    repeat (2) begin
      step();
      chk("busy_ready", 64'(o_ready), 64'd0);
      nl += (o_cmd == 2'd1) ? 1 : 0;
    end
    force_resp = 6;
    step();
    nl += (o_cmd == 2'd1) ? 1 : 0;
    chk("busy_loads", 64'(nl), 64'd4);
    idle(1);
    fill(4'd6, 64'h66);
    chk("busy_fill_id", 64'(lsq_resp_id), 64'd9);

    // MSHR full
    for (int i = 0; i < 4; i++)
      req(1'b0, 64'h10000 + 64'(i * 8), 64'h0, 5'(11 + i), 1 + i);
    idle(1);
    chk("full_ready", 64'(o_ready), 64'd0);
    fill(4'd2, 64'h22);
    chk("full_fill_id", 64'(lsq_resp_id), 64'd12);
    idle(1);
    chk("refree_ready", 64'(o_ready), 64'd1);
    fill(4'd1, 64'h11); fill(4'd3, 64'h33); fill(4'd4, 64'h44);

    // stale fill
    req(1'b0, 64'h2000, 64'h0, 5'd4, 7);
    req(1'b1, 64'h2000, 64'h77, 5'd5, 8);
    chk("st_resp_id", 64'(lsq_resp_id), 64'd5);
    fill(4'd7, 64'h55);
    chk("stale_wrB_en", 64'(o_wrb_en), 64'd0);
    chk("stale_data", lsq_resp_data, 64'h55);
    chk("stale_cache", ecache[61'(64'h2000 >> 3)], 64'h77);
    req(1'b0, 64'h2000, 64'h0, 5'd6, 0);
    chk("stale_hit", lsq_resp_data, 64'h77);

    // store retry
    req(1'b1, 64'h4000, 64'h99, 5'd2, 0);
    force_resp = 11; step(); force_resp = -1;
    chk("st_retry_data", lsq_resp_data, 64'h99);

    // reset with two misses outstanding
    req(1'b0, 64'h3000, 64'h0, 5'd1, 9);
    req(1'b0, 64'h3008, 64'h0, 5'd2, 10);
    s_rst = 1'b1; step(); s_rst = 1'b0;
    fill(4'd9, 64'h9);
    chk("rst_drop9", 64'(lsq_resp_valid), 64'd0);
    fill(4'd10, 64'hA);
    chk("rst_drop10", 64'(lsq_resp_valid), 64'd0);
    chk("rst_after_ready", 64'(o_ready), 64'd1);

    // random traffic
    for (int it = 0; it < 3000; it++) begin
      int r;
      s_rst = ($urandom_range(0, 499) == 0);
      s_valid = ($urandom_range(0, 9) < 6);
      s_store = ($urandom_range(0, 9) < 3);
      s_addr = {31'h0, 1'($urandom_range(0, 1)),
                32'(($urandom_range(0, 7) << 9) | ($urandom_range(0, 3) << 3) | $urandom_range(0, 7))};
      s_data = {$urandom, $urandom};
      s_id = ID_W'($urandom);
      s_mdata = {$urandom, $urandom};
      r = $urandom_range(0, 9);
      s_tag = 4'd0;
      if (r < 4 && mm.num() > 0) begin
        keys.delete();
        foreach (mm[k]) keys.push_back(k);
        s_tag = 4'(keys[$urandom_range(0, keys.size() - 1)]);
      end else if (r < 5) begin
        s_tag = 4'($urandom_range(1, 15));
      end
      force_resp = -1;
      step();
    end
    s_rst = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
